// File: rtl/dac_pkg.sv
// Shared constants for the LTC2624 serial write path: frame layout,
// controller state encoding and the common command/address codes.
package dac_pkg;

    // One LTC2624 write is a 32-bit word shifted MSB first
    localparam int unsigned FRAME_BITS = 32;
    localparam int unsigned BITCNT_W   = 6;
    localparam int unsigned TICK_W     = 8;

    // Field positions inside the 32-bit frame
    localparam int unsigned CMD_MSB  = 23;
    localparam int unsigned CMD_LSB  = 20;
    localparam int unsigned ADDR_MSB = 19;
    localparam int unsigned ADDR_LSB = 16;
    localparam int unsigned DATA_MSB = 15;
    localparam int unsigned DATA_LSB = 4;

    // Frequently used command / address codes
    localparam logic [3:0] CMD_WRITE_UPDATE = 4'h3;
    localparam logic [3:0] ADDR_ALL         = 4'hF;

    // Controller state encoding
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SHIFT_LO = 3'd1;
    localparam logic [2:0] ST_SHIFT_HI = 3'd2;
    localparam logic [2:0] ST_CS_HOLD  = 3'd3;
    localparam logic [2:0] ST_CS_GAP   = 3'd4;

    // Assemble {8'h00, cmd, addr, data, 4'h0}
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [3:0]  cmd,
        input logic [3:0]  addr,
        input logic [11:0] data
    );
        logic [FRAME_BITS-1:0] f;
        f                    = '0;
        f[CMD_MSB:CMD_LSB]   = cmd;
        f[ADDR_MSB:ADDR_LSB] = addr;
        f[DATA_MSB:DATA_LSB] = data;
        return f;
    endfunction

endpackage

// File: rtl/dac_spi_tick.sv
// Phase tick generator: a down-counter that pulses o_tick once every
// CLK_DIV cycles. While i_restart is high the counter is parked at its
// reload value, so the first tick lands exactly CLK_DIV cycles after
// i_restart drops.
module dac_spi_tick
    import dac_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_restart,
    output logic o_tick
);

    localparam logic [TICK_W-1:0] RELOAD = TICK_W'(CLK_DIV - 1);

    logic [TICK_W-1:0] r_cnt;
    logic              w_zero;

    assign w_zero = (r_cnt == '0);
    assign o_tick = w_zero && !i_restart;

    // Count down, reloading on restart or on reaching zero
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= RELOAD;
        end else if (i_restart || w_zero) begin
            r_cnt <= RELOAD;
        end else begin
            r_cnt <= r_cnt - TICK_W'(1);
        end
    end

endmodule

// File: rtl/dac_spi_writer.sv
// LTC2624 serial write engine. Latches cmd/addr/data on an accepted start,
// shifts one 32-bit frame out MSB first with SCK = CLK50MHZ / (2*CLK_DIV),
// then releases DAC_CS to update the DAC and pulses done.
module dac_spi_writer
    import dac_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic        CLK50MHZ,
    input  logic        RST,
    input  logic        start,
    input  logic [3:0]  cmd,
    input  logic [3:0]  addr,
    input  logic [11:0] data,
    output logic        busy,
    output logic        done,
    output logic        SPI_SCK,
    output logic        SPI_MOSI,
    output logic        DAC_CS,
    output logic        DAC_CLR
);

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [FRAME_BITS-1:0] r_shreg;
    logic [BITCNT_W-1:0]   r_bits;
    logic                  r_sck;
    logic                  r_mosi;
    logic                  r_cs;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_clr;

    logic [FRAME_BITS-1:0] w_frame;
    logic                  w_tick;
    logic                  w_restart;
    logic                  w_accept;
    logic                  w_rise;
    logic                  w_shift;
    logic                  w_last_bit;
    logic                  w_hold_end;

    assign w_frame    = build_frame(cmd, addr, data);
    assign w_restart  = (r_state == ST_IDLE);
    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_rise     = (r_state == ST_SHIFT_LO) && w_tick;
    assign w_shift    = (r_state == ST_SHIFT_HI) && w_tick;
    assign w_last_bit = (r_bits == BITCNT_W'(1));
    assign w_hold_end = (r_state == ST_CS_HOLD) && w_tick;

    // Phase timer: parked in IDLE, so it restarts on the accepting edge
    dac_spi_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .i_clk     (CLK50MHZ),
        .i_rst     (RST),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    // Next-state selection
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_LO: begin
                if (w_tick) begin
                    w_state_nxt = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                if (w_tick) begin
                    w_state_nxt = w_last_bit ? ST_CS_HOLD : ST_SHIFT_LO;
                end
            end
            ST_CS_HOLD: begin
                if (w_tick) begin
                    w_state_nxt = ST_CS_GAP;
                end
            end
            ST_CS_GAP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame shift register and remaining-bit counter
    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            r_shreg <= '0;
            r_bits  <= '0;
        end else if (w_accept) begin
            r_shreg <= w_frame;
            r_bits  <= BITCNT_W'(FRAME_BITS);
        end else if (w_shift) begin
            r_shreg <= {r_shreg[FRAME_BITS-2:0], 1'b0};
            r_bits  <= r_bits - BITCNT_W'(1);
        end
    end

    // Serial clock: high for one phase per bit, low otherwise
    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            r_sck <= 1'b0;
        end else if (w_rise) begin
            r_sck <= 1'b1;
        end else if (w_shift || w_accept) begin
            r_sck <= 1'b0;
        end
    end

    // Serial data: next bit is presented on the same edge SCK falls,
    // so MOSI only moves while SCK is low
    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            r_mosi <= 1'b0;
        end else if (w_accept) begin
            r_mosi <= w_frame[FRAME_BITS-1];
        end else if (w_shift) begin
            r_mosi <= w_last_bit ? 1'b0 : r_shreg[FRAME_BITS-2];
        end
    end

    // Chip select, busy flag and completion pulse
    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            r_cs   <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_hold_end;
            if (w_accept) begin
                r_cs   <= 1'b0;
                r_busy <= 1'b1;
            end else if (w_hold_end) begin
                r_cs <= 1'b1;
            end else if (r_state == ST_CS_GAP) begin
                r_busy <= 1'b0;
            end
        end
    end

    // DAC clear: held active through reset, released on the first edge after
    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            r_clr <= 1'b0;
        end else begin
            r_clr <= 1'b1;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign SPI_SCK  = r_sck;
    assign SPI_MOSI = r_mosi;
    assign DAC_CS   = r_cs;
    assign DAC_CLR  = r_clr;

endmodule

// File: tb/tb_dac_spi_writer.sv
// Bench for dac_spi_writer: two instances (CLK_DIV=2 and CLK_DIV=1), an
// SCK-rising capture monitor per instance and a scoreboard of expected frames.
module tb_dac_spi_writer;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic [3:0]  cmd0 = '0, addr0 = '0, cmd1 = '0, addr1 = '0;
    logic [11:0] data0 = '0, data1 = '0;
    logic        busy0, done0, sck0, mosi0, cs0, clr0;
    logic        busy1, done1, sck1, mosi1, cs1, clr1;
    logic [1:0]  busy, dn, sck, mosi, cs;

    int n_tests = 0;
    int n_fail  = 0;

    assign busy = {busy1, busy0};
    assign dn   = {done1, done0};
    assign sck  = {sck1, sck0};
    assign mosi = {mosi1, mosi0};
    assign cs   = {cs1, cs0};

    always #10 clk = ~clk;

    dac_spi_writer #(.CLK_DIV(2)) u_dut_d2 (
        .CLK50MHZ (clk), .RST (RST), .start (start0),
        .cmd (cmd0), .addr (addr0), .data (data0),
        .busy (busy0), .done (done0), .SPI_SCK (sck0), .SPI_MOSI (mosi0),
        .DAC_CS (cs0), .DAC_CLR (clr0)
    );

    dac_spi_writer #(.CLK_DIV(1)) u_dut_d1 (
        .CLK50MHZ (clk), .RST (RST), .start (start1),
        .cmd (cmd1), .addr (addr1), .data (data1),
        .busy (busy1), .done (done1), .SPI_SCK (sck1), .SPI_MOSI (mosi1),
        .DAC_CS (cs1), .DAC_CLR (clr1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard and monitor state
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    int          gaps[$];
    logic [31:0] cap[2];
    int          nbits[2], lowcnt[2], hicnt[2], since_rise[2], minp[2], maxp[2];
    int          done_cnt[2]  = '{0, 0};
    int          frames_ok[2] = '{0, 0};
    logic        prev_sck[2], prev_cs[2], armed[2];

    // Capture MOSI on each SCK rise while CS is low; score the frame when CS rises
    always @(negedge clk) begin : monitor
        logic [31:0] e;
        int          qs;
        for (int i = 0; i < 2; i++) begin
            if (RST) begin
                cap[i] = '0; nbits[i] = 0; lowcnt[i] = 0; hicnt[i] = 0;
                since_rise[i] = 0; minp[i] = 1000; maxp[i] = 0;
                prev_sck[i] = 1'b0; prev_cs[i] = 1'b1; armed[i] = 1'b0;
                if (i == 0) exp_q0.delete(); else exp_q1.delete();
            end else begin
                if (dn[i]) done_cnt[i]++;
                if (!cs[i]) begin
                    if (prev_cs[i]) begin
                        if (i == 0 && armed[0]) gaps.push_back(hicnt[0]);
                        cap[i] = '0; nbits[i] = 0; lowcnt[i] = 1;
                        since_rise[i] = 0; minp[i] = 1000; maxp[i] = 0;
                    end else begin
                        lowcnt[i]++;
                    end
                    since_rise[i]++;
                    if (sck[i] && !prev_sck[i]) begin
                        cap[i] = {cap[i][30:0], mosi[i]};
                        if (nbits[i] > 0) begin
                            if (since_rise[i] < minp[i]) minp[i] = since_rise[i];
                            if (since_rise[i] > maxp[i]) maxp[i] = since_rise[i];
                        end
                        nbits[i]++;
                        since_rise[i] = 0;
                    end
                end else if (!prev_cs[i]) begin
                    qs = (i == 0) ? exp_q0.size() : exp_q1.size();
                    check(i == 0 ? "d2_frame_expected" : "d1_frame_expected", 32'(qs != 0), 32'd1);
                    if (qs != 0) begin
                        if (i == 0) e = exp_q0.pop_front(); else e = exp_q1.pop_front();
                        check(i == 0 ? "d2_frame_word" : "d1_frame_word", cap[i], e);
                    end
                    check(i == 0 ? "d2_sck_rises" : "d1_sck_rises", nbits[i], 32);
                    check(i == 0 ? "d2_cs_low_cycles" : "d1_cs_low_cycles", lowcnt[i], (i == 0) ? 130 : 65);
                    check(i == 0 ? "d2_done_with_cs" : "d1_done_with_cs", 32'(dn[i]), 32'd1);
                    check(i == 0 ? "d2_sck_period_min" : "d1_sck_period_min", minp[i], (i == 0) ? 4 : 2);
                    check(i == 0 ? "d2_sck_period_max" : "d1_sck_period_max", maxp[i], (i == 0) ? 4 : 2);
                    frames_ok[i]++;
                    hicnt[i] = 1;
                    armed[i] = 1'b1;
                end else begin
                    hicnt[i]++;
                end
                prev_cs[i]  = cs[i];
                prev_sck[i] = sck[i];
            end
        end
    end

    // Drive one start pulse, push the expected frame, then scramble the inputs
    task automatic start_frame(input int i, input logic [3:0] c, input logic [3:0] a, input logic [11:0] d);
        @(negedge clk);
        if (i == 0) begin
            start0 = 1'b1; cmd0 = c; addr0 = a; data0 = d;
            exp_q0.push_back({8'h00, c, a, d, 4'h0});
        end else begin
            start1 = 1'b1; cmd1 = c; addr1 = a; data1 = d;
            exp_q1.push_back({8'h00, c, a, d, 4'h0});
        end
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        cmd0 = 4'($urandom); addr0 = 4'($urandom); data0 = 12'($urandom);
        cmd1 = 4'($urandom); addr1 = 4'($urandom); data1 = 12'($urandom);
    endtask

    // Wait (bounded) for done; optionally pulse a stray start on instance 0
    task automatic wait_done(input int i, input int inject, input int exp_n, input string tag);
        int n;
        n = 0;
        check({tag, "_busy_after_accept"}, 32'(busy[i]), 32'd1);
        while (dn[i] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
            if (inject > 0 && n == inject)     start0 = 1'b1;
            if (inject > 0 && n == inject + 1) start0 = 1'b0;
        end
        check({tag, "_done_cycle"}, n, exp_n);
        @(negedge clk);
        check({tag, "_busy_released"}, 32'(busy[i]), 32'd0);
        check({tag, "_done_one_cycle"}, 32'(dn[i]), 32'd0);
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stim
        int rises, guard, dc_before;
        logic ps;

        // 1: reset values and release
        repeat (3) @(negedge clk);
        check("rst_cs",    32'(cs0),   32'd1);
        check("rst_sck",   32'(sck0),  32'd0);
        check("rst_mosi",  32'(mosi0), 32'd0);
        check("rst_clr",   32'(clr0),  32'd0);
        check("rst_busy",  32'(busy0), 32'd0);
        check("rst_done",  32'(done0), 32'd0);
        check("rst_cs_d1", 32'(cs1),   32'd1);
        #2 RST = 1'b0;
        #1 check("clr_before_edge", 32'(clr0), 32'd0);
        @(negedge clk);
        check("clr_released",    32'(clr0), 32'd1);
        check("clr_released_d1", 32'(clr1), 32'd1);

        // 2 + 3: D=2 write, stray start at t+40 must be ignored
        start_frame(0, 4'h3, 4'h0, 12'h800);
        wait_done(0, 40, 130, "d2_first");
        repeat (10) @(negedge clk);
        check("stray_start_not_queued", 32'(busy0), 32'd0);
        check("one_frame_so_far", frames_ok[0], 1);
        start_frame(0, 4'h3, 4'h2, 12'hABC);
        wait_done(0, 0, 130, "d2_second");

        // 4: asynchronous reset after the 10th SCK rise
        repeat (3) @(negedge clk);
        start_frame(0, 4'h3, 4'h5, 12'h555);
        rises = 0; guard = 0; ps = sck0;
        while (rises < 10 && guard < 500) begin
            @(negedge clk);
            guard++;
            if (sck0 && !ps) rises++;
            ps = sck0;
        end
        check("reached_10th_rise", rises, 10);
        dc_before = done_cnt[0];
        #2 RST = 1'b1;
        #1;
        check("async_rst_cs",   32'(cs0),   32'd1);
        check("async_rst_sck",  32'(sck0),  32'd0);
        check("async_rst_busy", 32'(busy0), 32'd0);
        check("async_rst_mosi", 32'(mosi0), 32'd0);
        check("async_rst_clr",  32'(clr0),  32'd0);
        @(negedge clk);
        #2 RST = 1'b0;
        repeat (3) @(negedge clk);
        check("no_done_after_abort", done_cnt[0], dc_before);
        start_frame(0, 4'h3, 4'h1, 12'h123);
        wait_done(0, 0, 130, "d2_after_rst");

        // 5: start held high for 300 cycles
        repeat (4) @(negedge clk);
        dc_before = done_cnt[0];
        @(negedge clk);
        start0 = 1'b1; cmd0 = 4'h3; addr0 = 4'h7; data0 = 12'h3C5;
        repeat (3) exp_q0.push_back(32'h00373C50);
        @(negedge clk);
        check("held_busy", 32'(busy0), 32'd1);
        @(negedge clk);
        #1 gaps.delete();
        repeat (298) @(negedge clk);
        start0 = 1'b0;
        guard = 0;
        while (busy0 !== 1'b0 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("held_ends_idle", 32'(busy0), 32'd0);
        repeat (2) @(negedge clk);
        check("held_gap_count", gaps.size(), 2);
        if (gaps.size() >= 2) begin
            check("held_gap_1", gaps[0], 2);
            check("held_gap_2", gaps[1], 2);
        end
        check("held_done_pulses", done_cnt[0] - dc_before, 3);

        // 6: D=1 full-scale write to all channels
        start_frame(1, 4'h3, 4'hF, 12'hFFF);
        wait_done(1, 0, 65, "d1_frame");

        repeat (5) @(negedge clk);
        check("d2_queue_drained", exp_q0.size(), 0);
        check("d1_queue_drained", exp_q1.size(), 0);
        check("d2_done_per_frame", done_cnt[0], frames_ok[0]);
        check("d1_done_per_frame", done_cnt[1], frames_ok[1]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
